// File: rtl/wisc_pkg.sv
// Shared WISC decode/execute definitions: opcode and condition encodings,
// the halt-state enum and the ID/EX control bundle.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} halt_st_e;

  // Width-independent part of ID/EX; operands travel alongside at DATA_W.
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        z_en;
    logic        nv_en;
    logic        mem_en;
    logic        mem_wr;
    logic [3:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        hlt;
    logic        pcs;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] pc_next;
  } id_ex_ctrl_t;

  // flags = {Z,V,N}
  function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flags);
    logic z, v, n;
    {z, v, n} = flags;
    case (ccc)
      CC_NE:   return !z;
      CC_EQ:   return z;
      CC_GT:   return !z && !n;
      CC_LT:   return n;
      CC_GE:   return z || !n;
      CC_LE:   return z || n;
      CC_OV:   return v;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with optional hard-zero R0 and
// same-cycle write-to-read bypass.
module regfile_bypass #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter bit R0_ZERO   = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ra1,
  input  logic [3:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr_ok;

  // Out-of-range and (optionally) R0 writes are dropped, which also keeps them off the bypass.
  assign wr_ok = we && (int'(wa) < NUM_REGS) && !(R0_ZERO && wa == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wa == 4'(i)) regs[i] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra1 == 4'(i)) rd1 = regs[i];
      if (ra2 == 4'(i)) rd2 = regs[i];
    end
    if (R0_ZERO && ra1 == 4'd0) rd1 = '0;
    if (R0_ZERO && ra2 == 4'd0) rd2 = '0;
    if (WB_BYPASS && wr_ok && wa == ra1) rd1 = wd;
    if (WB_BYPASS && wr_ok && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// WISC decode stage: operand read, control decode, branch resolution,
// hazard stalls, halt tracking and the registered ID/EX bundle.
module decode_stage_pipe
  import wisc_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter bit R0_ZERO   = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [15:0]       if_inst,
  input  logic [15:0]       if_pc_next,
  output logic              id_ready,
  input  logic [2:0]        flags,
  input  logic              ex_stall,
  input  logic [3:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [3:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              br_taken,
  output logic [15:0]       br_target,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_op,
  output logic              ex_z_en,
  output logic              ex_nv_en,
  output logic              ex_mem_en,
  output logic              ex_mem_wr,
  output logic [3:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_hlt,
  output logic              ex_pcs,
  output logic [3:0]        ex_rs,
  output logic [3:0]        ex_rt,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [15:0]       ex_pc_next
);

  logic [3:0]        op, f_rd, f_rs, f_rt, src1, src2;
  logic [DATA_W-1:0] d1, d2, in2_d;
  logic              use1, use2, is_br, load_use, flag_haz, reg_haz, hazard, accept;
  logic [15:0]       b_off;
  halt_st_e          state, state_nxt;
  id_ex_ctrl_t       ctrl_q, ctrl_d;
  logic [DATA_W-1:0] in1_q, in2_q, sd_q;

  assign {op, f_rd, f_rs, f_rt} = if_inst;
  assign src1 = (op == OP_LLB || op == OP_LHB) ? f_rd : f_rs;
  assign src2 = (op == OP_SW) ? f_rd : f_rt;
  assign use1 = (op <= OP_LHB) || (op == OP_BR);
  assign use2 = op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB, OP_SW};
  assign is_br = (op == OP_B) || (op == OP_BR);

  regfile_bypass #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .R0_ZERO(R0_ZERO), .WB_BYPASS(WB_BYPASS)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(src1), .ra2(src2), .rd1(d1), .rd2(d2),
    .we(wb_reg_write), .wa(wb_rd), .wd(wb_data)
  );

  // Hazards only matter for an instruction actually presented by IF/ID.
  assign load_use = ctrl_q.valid && ctrl_q.mem_to_reg &&
                    ((use1 && src1 == ctrl_q.rd && !(R0_ZERO && src1 == 4'd0)) ||
                     (use2 && src2 == ctrl_q.rd && !(R0_ZERO && src2 == 4'd0)));
  assign flag_haz = is_br && ctrl_q.valid && (ctrl_q.z_en || ctrl_q.nv_en);
  assign reg_haz  = (op == OP_BR) &&
                    ((ctrl_q.valid && ctrl_q.reg_write && ctrl_q.rd == f_rs) ||
                     (mem_reg_write && mem_rd == f_rs));
  assign hazard   = if_valid && (load_use || flag_haz || reg_haz);

  assign id_ready = !ex_stall && (state == ST_RUN) && !hazard;
  assign accept   = if_valid && id_ready;

  assign b_off     = {{6{if_inst[8]}}, if_inst[8:0], 1'b0};
  assign br_taken  = rst_n && accept && is_br && cond_met(if_inst[11:9], flags);
  assign br_target = !br_taken     ? if_pc_next :
                     (op == OP_B)  ? if_pc_next + b_off : d1[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (accept && op == OP_HLT) state_nxt = ST_HALTED;
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = 1'b1;
    ctrl_d.alu_op     = op;
    ctrl_d.z_en       = op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR};
    ctrl_d.nv_en      = op inside {OP_ADD, OP_SUB};
    ctrl_d.mem_en     = op inside {OP_LW, OP_SW};
    ctrl_d.mem_wr     = (op == OP_SW);
    ctrl_d.rd         = f_rd;
    ctrl_d.reg_write  = op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR,
                                   OP_PADDSB, OP_LW, OP_LLB, OP_LHB, OP_PCS};
    ctrl_d.mem_to_reg = (op == OP_LW);
    ctrl_d.hlt        = (op == OP_HLT);
    ctrl_d.pcs        = (op == OP_PCS);
    ctrl_d.rs         = src1;
    ctrl_d.rt         = src2;
    ctrl_d.pc_next    = if_pc_next;
    case (op)
      OP_LW, OP_SW:          in2_d = {{(DATA_W-4){if_inst[3]}}, if_inst[3:0]};
      OP_SLL, OP_SRA, OP_ROR: in2_d = {{(DATA_W-4){1'b0}}, if_inst[3:0]};
      OP_LLB, OP_LHB:        in2_d = {{(DATA_W-8){1'b0}}, if_inst[7:0]};
      default:               in2_d = d2;
    endcase
  end

  // Held on ex_stall; otherwise an unaccepted cycle inserts an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      in1_q  <= '0;
      in2_q  <= '0;
      sd_q   <= '0;
    end else if (!ex_stall) begin
      if (accept) begin
        ctrl_q <= ctrl_d;
        in1_q  <= d1;
        in2_q  <= in2_d;
        sd_q   <= d2;
      end else begin
        ctrl_q <= '0;
        in1_q  <= '0;
        in2_q  <= '0;
        sd_q   <= '0;
      end
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_z_en       = ctrl_q.z_en;
  assign ex_nv_en      = ctrl_q.nv_en;
  assign ex_mem_en     = ctrl_q.mem_en;
  assign ex_mem_wr     = ctrl_q.mem_wr;
  assign ex_rd         = ctrl_q.rd;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_hlt        = ctrl_q.hlt;
  assign ex_pcs        = ctrl_q.pcs;
  assign ex_rs         = ctrl_q.rs;
  assign ex_rt         = ctrl_q.rt;
  assign ex_pc_next    = ctrl_q.pc_next;
  assign ex_in1        = in1_q;
  assign ex_in2        = in2_q;
  assign ex_store_data = sd_q;

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised next-generation decode stage for the WISC pipeline. Contains:
- the register file with write-to-read bypass
- the control decode and branch resolution
- load-use and branch-operand hazard detection
- a halt state machine
- the registered ID/EX pipeline bundle with valid, stall and bubble insertion

It sits between the IF/ID register and the execute stage. Everything leaving toward EX is registered.

Parameters:
DATA_W, 16, datapath and register width (>=16; instruction and PC stay 16 bits)
NUM_REGS, 16, register count (<=16, indexed by 4-bit fields; indices >= NUM_REGS read 0, writes ignored)
R0_ZERO, 1, 1 = R0 reads 0 and ignores writes
WB_BYPASS, 1, 1 = same-cycle WB write to a read register returns the write data

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_inst  in  16  instruction word
if_pc_next  in  16  PC+2 of that instruction
id_ready  out  1  decode accepts the instruction this cycle (0 = stall fetch)
flags  in  3  {Z,V,N} flag register
ex_stall  in  1  downstream stall; hold the ID/EX bundle
mem_rd  in  4  EX/MEM destination
mem_reg_write  in  1  EX/MEM writes a register
wb_rd  in  4  MEM/WB destination
wb_reg_write  in  1  MEM/WB write enable
wb_data  in  DATA_W  write-back data
br_taken  out  1  redirect fetch (combinational, qualified by accept)
br_target  out  16  redirect address
ex_valid  out  1  ID/EX bundle valid
ex_alu_op  out  4  ALU op (= opcode)
ex_z_en, ex_nv_en  out  1 each  flag write enables
ex_mem_en, ex_mem_wr  out  1 each  memory enable and write
ex_rd  out  4  destination
ex_reg_write, ex_mem_to_reg, ex_hlt, ex_pcs  out  1 each  WB controls
ex_rs, ex_rt  out  4 each  source IDs for the forwarding unit
ex_in1, ex_in2, ex_store_data  out  DATA_W each  operands
ex_pc_next  out  16  PC+2 for PCS

Behaviour:
Reset:
- All ex_* outputs are 0; the halt FSM goes to RUN.
- Registers clear to 0.
- br_taken=0 while rst_n is low.

Opcode map:
- 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR, 7 PADDSB, 8 LW, 9 SW, A LLB, B LHB, C B, D BR, E PCS, F HLT.
- Flag enables: ADD/SUB set Z and NV; XOR/SLL/SRA/ROR set Z only.

Operands:
- Source 1 is Rd for LLB/LHB, else Rs.
- Source 2 is Rd for SW, else Rt.
- ex_in2:
  - LW/SW: sign-extended inst[3:0]
  - SLL/SRA/ROR: zero-extended inst[3:0]
  - LLB/LHB: zero-extended inst[7:0]
  - otherwise: source-2 data
- ex_store_data = source-2 data.

Branch resolution (only when the instruction is accepted):
- ccc=inst[11:9] with flags {Z,V,N}:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GE: Z|!N
  - 101 LE: Z|N
  - 110 OV: V
  - 111 always
- B target = if_pc_next + (sext(inst[8:0])<<1), modulo 2^16.
- BR target = Rs[15:0].
- Not taken: br_target = if_pc_next.

Hazards (stall means id_ready=0; a bubble, ex_valid=0, enters ID/EX unless ex_stall):
- Load-use: ID/EX valid LW whose ex_rd matches a used source register (nonzero when R0_ZERO) → 1-cycle stall.
- Branch flag: B/BR while ID/EX valid has ex_z_en|ex_nv_en → stall until that instruction leaves EX.
- BR register: Rs matches a valid ID/EX ex_rd with reg_write, or mem_rd with mem_reg_write → stall.
- Downstream: ex_stall=1 → bundle held, id_ready=0, hazard stalls ignored that cycle.

Accept and advance:
- accept = if_valid & id_ready.
- On accept the bundle loads next cycle with ex_valid=1 (latency 1).
- if_valid=0 and no ex_stall → bubble.

Halt FSM:
- RUN: an accepted HLT loads the bundle and goes to HALTED.
- HALTED: id_ready=0 permanently and bubbles are issued; leaves only on reset.
- rst_n asserting mid-stall or in HALTED returns to RUN next cycle with no residual stall.

Register file:
- Write on the clk rising edge.
- With WB_BYPASS, a read of wb_rd during wb_reg_write returns wb_data.

Decomposition:
- Package wisc_pkg holds:
  - opcode localparams
  - condition-code constants
  - the halt-state enum
  - the packed ID/EX bundle struct, shared with the execute stage
- One natural sub-module: regfile_bypass (register file plus bypass, parametrised by DATA_W/NUM_REGS/R0_ZERO/WB_BYPASS).
- Hazard and branch logic stay inline.

Test Plan:
- Write R3=0x0005 via WB, then ADD R1,R3,R3 → next cycle ex_valid=1, ex_in1=ex_in2=0x0005, ex_alu_op=0, ex_z_en=ex_nv_en=1.
- LW R2,R4,-1 followed by ADD R5,R2,R6 → LW bundle with ex_in2=0xFFFF, then one bubble, then ADD with id_ready=1.
- ADD (flag-writing) then B EQ imm=0x1FE with Z=1, if_pc_next=0x0010 → 1-cycle stall, then br_taken=1, br_target=0x000C.
- Same-cycle WB write R7=0xBEEF and BR R7 (ccc=111), no hazards → br_target=0xBEEF; with WB_BYPASS=0 → old R7 value.
- HLT accepted → ex_hlt=1 one cycle, id_ready stays 0 for 10 further cycles with ex_valid=0; assert rst_n low → all ex_* =0, id_ready=1 after release.
- ex_stall=1 for 3 cycles mid-stream → ex_* held constant, id_ready=0; R0_ZERO=1 with WB write R0=0x1234 → R0 still reads 0x0000.
